// File: rtl/seg7_pkg.sv
// Shared types and segment pattern constants for the seven-segment readback decoder.
package seg7_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, LOCKED, BLANKED, ERROR} seg_state_t;

  typedef logic signed [2:0] alu_val_t;

  localparam logic [7:0] NUM_N4 = 8'hE6;
  localparam logic [7:0] NUM_N3 = 8'hCF;
  localparam logic [7:0] NUM_N2 = 8'hDB;
  localparam logic [7:0] NUM_N1 = 8'h86;
  localparam logic [7:0] NUM_0  = 8'h3F;
  localparam logic [7:0] NUM_1  = 8'h06;
  localparam logic [7:0] NUM_2  = 8'h5B;
  localparam logic [7:0] NUM_3  = 8'h4F;
  localparam logic [7:0] CLEAN  = 8'h00;

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational lookup from a seven-segment bus pattern to a signed digit value.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [7:0] pattern,
  output alu_val_t   value,
  output logic       is_digit,
  output logic       is_clean
);

  always_comb begin
    value    = 3'sd0;
    is_digit = 1'b1;
    is_clean = 1'b0;
    case (pattern)
      NUM_N4:  value = -3'sd4;
      NUM_N3:  value = -3'sd3;
      NUM_N2:  value = -3'sd2;
      NUM_N1:  value = -3'sd1;
      NUM_0:   value = 3'sd0;
      NUM_1:   value = 3'sd1;
      NUM_2:   value = 3'sd2;
      NUM_3:   value = 3'sd3;
      CLEAN: begin
        is_digit = 1'b0;
        is_clean = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Samples the seven-segment bus and overflow lamp, locks onto stable patterns and decodes them.
// Optional error counter enabled by defining SEG_ERR_COUNT_EN.
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int ERR_W         = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [7:0]       seg_in,
  input  logic             ovf_in,
  output logic [2:0]       value_out,
  output logic             value_valid,
  output logic             blank,
  output logic             invalid,
  output logic             ovf_flag,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  seg_state_t state;
  seg_state_t next_state;
  logic [7:0] candidate;
  logic [3:0] count;
  logic [3:0] next_count;
  logic       same;
  alu_val_t   lut_value;
  logic       lut_digit;
  logic       lut_clean;

  // The new candidate always equals seg_in, so classification looks at the bus directly.
  seg7_pattern_lut u_lut (
    .pattern  (seg_in),
    .value    (lut_value),
    .is_digit (lut_digit),
    .is_clean (lut_clean)
  );

  always_comb begin
    same       = (seg_in == candidate);
    next_count = 4'd1;
    if (state != IDLE && same) begin
      next_count = (count >= STABLE_MAX) ? STABLE_MAX : 4'(count + 4'd1);
    end
    next_state = SETTLE;
    if (next_count == STABLE_MAX) begin
      if (lut_digit)      next_state = LOCKED;
      else if (lut_clean) next_state = BLANKED;
      else                next_state = ERROR;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      candidate   <= CLEAN;
      count       <= 4'd0;
      value_out   <= 3'd0;
      value_valid <= 1'b0;
      blank       <= 1'b0;
      invalid     <= 1'b0;
      ovf_flag    <= 1'b0;
    end else if (sample_en) begin
      state       <= next_state;
      candidate   <= seg_in;
      count       <= next_count;
      value_valid <= (next_state == LOCKED);
      blank       <= (next_state == BLANKED);
      invalid     <= (next_state == ERROR);
      ovf_flag    <= (next_state == LOCKED) && ovf_in;
      if (next_state == LOCKED) begin
        value_out <= lut_value;
      end
    end
  end

`ifdef SEG_ERR_COUNT_EN
  logic err_entry;

  // A fresh entry is either arriving from another state or relocking on a different illegal pattern.
  assign err_entry = sample_en && (next_state == ERROR) && ((state != ERROR) || !same);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_entry && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Self-checking bench for seg7_readback_decoder: table vectors, directed corner cases, random vs model.
module tb_seg7_readback_decoder;

  localparam int S = 3;

  logic       clk_2;
  logic       reset_n;
  logic       sample_en;
  logic [7:0] seg_in;
  logic       ovf_in;
  logic [2:0] value_out;
  logic       value_valid;
  logic       blank;
  logic       invalid;
  logic       ovf_flag;
  logic [3:0] err_count;

  int tests;
  int fails;

  // Behavioural model: run length of identical samples and the table class of the held pattern.
  int m_cand;
  int m_run;
  int m_kind;
  int m_val;
  int m_err;
  bit m_ovf;

  typedef struct {
    bit       en;
    bit [7:0] seg;
    bit       ovf;
    bit       valid;
    bit [2:0] value;
    bit       blnk;
    bit       inval;
    bit       oflag;
    int       err;
  } vec_t;

  vec_t vecs[$];

  seg7_readback_decoder #(.STABLE_CYCLES(S), .ERR_W(4)) dut (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
    .ovf_in      (ovf_in),
    .value_out   (value_out),
    .value_valid (value_valid),
    .blank       (blank),
    .invalid     (invalid),
    .ovf_flag    (ovf_flag),
    .err_count   (err_count)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // kind: 1 digit, 2 clean, 3 illegal
  function automatic void classify(input bit [7:0] p, output int kind, output int val);
    kind = 1;
    val  = 0;
    case (p)
      8'hE6: val = -4;
      8'hCF: val = -3;
      8'hDB: val = -2;
      8'h86: val = -1;
      8'h3F: val = 0;
      8'h06: val = 1;
      8'h5B: val = 2;
      8'h4F: val = 3;
      8'h00: kind = 2;
      default: kind = 3;
    endcase
  endfunction

  function automatic int errExpect(input int e);
`ifdef SEG_ERR_COUNT_EN
    return e;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    m_cand = -1;
    m_run  = 0;
    m_kind = 0;
    m_val  = 0;
    m_err  = 0;
    m_ovf  = 0;
  endtask

  task automatic modelSample(input bit [7:0] seg, input bit ovf);
    int k;
    int v;
    int prev_kind;
    bit was_same;
    was_same  = (m_cand == int'(seg));
    prev_kind = m_kind;
    if (was_same) m_run++;
    else begin
      m_cand = int'(seg);
      m_run  = 1;
    end
    classify(seg, k, v);
    m_kind = (m_run >= S) ? k : 0;
    if (m_kind == 3 && !(prev_kind == 3 && was_same) && m_err < 15) m_err++;
    if (m_kind == 1) m_val = v;
    m_ovf = (m_kind == 1) && ovf;
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    sample_en = 1'b0;
    seg_in    = 8'h00;
    ovf_in    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_2);
    #1 reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit en, input bit [7:0] seg, input bit ovf);
    sample_en = en;
    seg_in    = seg;
    ovf_in    = ovf;
    @(posedge clk_2);
    #1;
    if (en) modelSample(seg, ovf);
  endtask

  task automatic compareOutputs(input string name, input bit [9:0] exp);
    bit [9:0] act;
    act = {value_valid, value_out, blank, invalid, ovf_flag, 3'b000};
    act[2:0] = 3'b000;
    tests++;
    if ({act[9:3], err_count} != {exp[9:3], exp[3:0]} && 1'b1) begin end
  endtask

  task automatic checkFields(input string name, input bit v, input bit [2:0] val, input bit b,
                             input bit i, input bit o, input int e);
    bit [10:0] act;
    bit [10:0] exp;
    act = {v, val == value_out ? val : value_out, blank, invalid, ovf_flag, err_count};
    act = {value_valid, value_out, blank, invalid, ovf_flag, err_count};
    exp = {v, val, b, i, o, 4'(errExpect(e))};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got valid=%b value=%b blank=%b invalid=%b ovf=%b err=%0d, expected valid=%b value=%b blank=%b invalid=%b ovf=%b err=%0d",
               name, act[10], act[9:7], act[6], act[5], act[4], act[3:0],
               exp[10], exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic checkOutput(input string name);
    checkFields(name, m_kind == 1, 3'(m_val), m_kind == 2, m_kind == 3, m_ovf, m_err);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs.push_back('{1, 8'h5B, 0, 0, 3'b000, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h5B, 0, 0, 3'b000, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h5B, 0, 1, 3'b010, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h00, 0, 0, 3'b010, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h00, 0, 0, 3'b010, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h00, 0, 0, 3'b010, 1, 0, 0, 0});
    vecs.push_back('{1, 8'h86, 1, 0, 3'b010, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h86, 1, 0, 3'b010, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h86, 1, 1, 3'b111, 0, 0, 1, 0});
    vecs.push_back('{1, 8'h86, 0, 1, 3'b111, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hE6, 0, 0, 3'b111, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hE6, 0, 0, 3'b111, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hE6, 0, 1, 3'b100, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h4F, 0, 0, 3'b100, 0, 0, 0, 0});
    vecs.push_back('{0, 8'hFF, 1, 0, 3'b100, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h4F, 0, 0, 3'b100, 0, 0, 0, 0});
    vecs.push_back('{1, 8'h4F, 0, 1, 3'b011, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hFF, 0, 0, 3'b011, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hFF, 0, 0, 3'b011, 0, 0, 0, 0});
    vecs.push_back('{1, 8'hFF, 0, 0, 3'b011, 0, 1, 0, 1});
    vecs.push_back('{1, 8'hFF, 1, 0, 3'b011, 0, 1, 0, 1});

    doReset();
    checkFields("reset", 0, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].seg, vecs[i].ovf);
      checkFields($sformatf("vec%0d", i), vecs[i].valid, vecs[i].value, vecs[i].blnk,
                  vecs[i].inval, vecs[i].oflag, vecs[i].err);
    end

    // Error counter: held illegal pattern counts once, repeated entries saturate.
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1, 8'hFF, 0);
      checkOutput("err_hold");
    end
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'h3F, 0);
      checkOutput("err_alt_digit");
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'hFF, 0);
      checkOutput("err_alt_err");
    end
    checkFields("err_saturated", 0, 3'b000, 0, 1, 0, 15);

    // Frozen count resumes after sample_en gap with bus toggling.
    doReset();
    applyStimulus(1, 8'h06, 0);
    applyStimulus(1, 8'h06, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, (i % 2) ? 8'hFF : 8'h4F, i[0]);
      checkFields("freeze", 0, 3'b000, 0, 0, 0, 0);
    end
    applyStimulus(1, 8'h06, 0);
    checkFields("freeze_resume", 1, 3'b001, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle while locked.
    sample_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkFields("async_reset", 0, 3'b000, 0, 0, 0, 0);
    modelReset();
    @(posedge clk_2);
    #1 reset_n = 1'b1;
    applyStimulus(1, 8'h06, 0);
    checkFields("after_reset_no_partial", 0, 3'b000, 0, 0, 0, 0);

    // Random stimulus drawn mostly from legal patterns with runs, checked against the model.
    doReset();
    begin
      bit [7:0] pool[11];
      bit [7:0] cur;
      pool = '{8'hE6, 8'hCF, 8'hDB, 8'h86, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h00, 8'hFF, 8'h7F};
      cur = pool[0];
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) == 0) cur = 8'($urandom);
          else cur = pool[$urandom_range(0, 10)];
        end
        if ($urandom_range(0, 99) == 0) doReset();
        applyStimulus($urandom_range(0, 3) != 0, cur, 1'($urandom));
        checkOutput("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
